// File: rtl/merlin_mtimer_pkg.sv
// Shared constants for the merlin machine timer: register indices,
// CTRL bit positions and the mtimecmp reset value.
package merlin_mtimer_pkg;

    // Register index, decoded from treqaddr_i[4:2]
    localparam logic [2:0] C_MTIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] C_MTIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] C_MTIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] C_MTIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] C_MTIMER_CTRL        = 3'd4;
    localparam logic [2:0] C_MTIMER_PRESCALE    = 3'd5;

    // CTRL bit positions
    localparam int unsigned C_MTIMER_CTRL_EN = 0;
    localparam int unsigned C_MTIMER_CTRL_IE = 1;

    // mtimecmp resets to all ones so no interrupt is pending out of reset
    localparam logic [63:0] C_MTIMER_MTIMECMP_RESET = '1;

endpackage

// File: rtl/merlin_mtimer_prescaler.sv
// Prescale counter for the merlin machine timer. Emits a one-cycle tick
// each time the counter reaches the programmed prescale value.
module merlin_mtimer_prescaler
    import merlin_mtimer_pkg::*;
#(
    parameter int unsigned C_PRESCALE_SZ = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     en,
    input  logic                     clear,
    input  logic [C_PRESCALE_SZ-1:0] prescale,
    output logic                     tick
);

    logic [C_PRESCALE_SZ-1:0] count;

    assign tick = clk_en & en & (count == prescale);

    // Count while enabled; wrap to zero on reaching prescale, or when prescale is rewritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clk_en) begin
            if (clear) begin
                count <= '0;
            end else if (en) begin
                count <= (count == prescale) ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/merlin_mtimer.sv
// Memory-mapped 64-bit machine timer with compare interrupt, a target on the
// merlin32i data-port dreq/drsp handshake.
module merlin_mtimer
    import merlin_mtimer_pkg::*;
#(
    parameter int unsigned C_PRESCALE_SZ = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic [31:0] trspdata_o,
    output logic        irq_o
);

    logic [63:0]              mtime;
    logic [63:0]              mtimecmp;
    logic [31:0]              hi_shadow;
    logic [1:0]               ctrl;
    logic [C_PRESCALE_SZ-1:0] prescale;
    logic                     tick;
    logic                     accept;
    logic                     wr;
    logic                     rd;
    logic [2:0]               idx;
    logic [31:0]              rdata;
    logic                     unused_addr;

    assign unused_addr = ^{treqaddr_i[31:5], treqaddr_i[1:0]};

    assign treqready_o = ~trspvalid_o | trspready_i;
    assign accept      = treqvalid_i & treqready_o;
    assign wr          = accept & treqdvalid_i;
    assign rd          = accept & ~treqdvalid_i;
    assign idx         = treqaddr_i[4:2];

    merlin_mtimer_prescaler #(
        .C_PRESCALE_SZ(C_PRESCALE_SZ)
    ) u_prescaler (
        .clk      (clk_i),
        .rst      (reset_i),
        .clk_en   (clk_en_i),
        .en       (ctrl[C_MTIMER_CTRL_EN]),
        .clear    (wr && idx == C_MTIMER_PRESCALE),
        .prescale (prescale),
        .tick     (tick)
    );

    // Read mux over current register values
    always_comb begin
        rdata = '0;
        case (idx)
            C_MTIMER_MTIME_LO:    rdata = mtime[31:0];
            C_MTIMER_MTIME_HI:    rdata = hi_shadow;
            C_MTIMER_MTIMECMP_LO: rdata = mtimecmp[31:0];
            C_MTIMER_MTIMECMP_HI: rdata = mtimecmp[63:32];
            C_MTIMER_CTRL:        rdata = {30'd0, ctrl};
            C_MTIMER_PRESCALE:    rdata = 32'(prescale);
            default:              rdata = '0;
        endcase
    end

    // mtime and shadow: a software write to either half beats the tick increment
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mtime     <= '0;
            hi_shadow <= '0;
        end else if (clk_en_i) begin
            if (wr && idx == C_MTIMER_MTIME_LO) begin
                mtime[31:0] <= treqdata_i;
            end else if (wr && idx == C_MTIMER_MTIME_HI) begin
                mtime[63:32] <= treqdata_i;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr && idx == C_MTIMER_MTIME_HI) begin
                hi_shadow <= treqdata_i;
            end else if (rd && idx == C_MTIMER_MTIME_LO) begin
                hi_shadow <= mtime[63:32];
            end
        end
    end

    // Compare, control and prescale registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mtimecmp <= C_MTIMER_MTIMECMP_RESET;
            ctrl     <= '0;
            prescale <= '0;
        end else if (clk_en_i && wr) begin
            case (idx)
                C_MTIMER_MTIMECMP_LO: mtimecmp[31:0]  <= treqdata_i;
                C_MTIMER_MTIMECMP_HI: mtimecmp[63:32] <= treqdata_i;
                C_MTIMER_CTRL:        ctrl            <= treqdata_i[1:0];
                C_MTIMER_PRESCALE:    prescale        <= treqdata_i[C_PRESCALE_SZ-1:0];
                default:              ;
            endcase
        end
    end

    // Registered interrupt level from the current register values
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_o <= 1'b0;
        end else if (clk_en_i) begin
            irq_o <= ctrl[C_MTIMER_CTRL_IE] & (mtime >= mtimecmp);
        end
    end

    // Single response register: load on read accept, clear on pop
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            trspvalid_o <= 1'b0;
            trspdata_o  <= '0;
        end else if (clk_en_i) begin
            if (rd) begin
                trspvalid_o <= 1'b1;
                trspdata_o  <= rdata;
            end else if (trspvalid_o && trspready_i) begin
                trspvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merlin_mtimer.sv
// Self-checking bench for merlin_mtimer: behavioural model plus directed vectors.
module tb_merlin_mtimer;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        treqready_o;
    logic        treqvalid_i = 1'b0;
    logic        treqdvalid_i = 1'b0;
    logic [31:0] treqaddr_i = '0;
    logic [31:0] treqdata_i = '0;
    logic        trspready_i = 1'b1;
    logic        trspvalid_o;
    logic [31:0] trspdata_o;
    logic        irq_o;

    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    merlin_mtimer #(.C_PRESCALE_SZ(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .clk_en_i     (clk_en_i),
        .treqready_o  (treqready_o),
        .treqvalid_i  (treqvalid_i),
        .treqdvalid_i (treqdvalid_i),
        .treqaddr_i   (treqaddr_i),
        .treqdata_i   (treqdata_i),
        .trspready_i  (trspready_i),
        .trspvalid_o  (trspvalid_o),
        .trspdata_o   (trspdata_o),
        .irq_o        (irq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow, m_rd;
    logic        m_en, m_ie, m_rv, m_irq;
    logic [15:0] m_ps;
    int unsigned m_phase;

    logic        t_acc, t_wr, t_rd, t_tick;
    logic [2:0]  t_idx;
    logic [31:0] t_val;

    function automatic logic [31:0] m_read(input logic [2:0] i);
        case (i)
            3'd0: return m_time[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ie, m_en};
            3'd5: return {16'd0, m_ps};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_time <= 64'd0; m_cmp <= {64{1'b1}}; m_shadow <= 32'd0;
            m_en <= 1'b0; m_ie <= 1'b0; m_ps <= 16'd0; m_phase <= 0;
            m_rv <= 1'b0; m_rd <= 32'd0; m_irq <= 1'b0;
        end else if (clk_en_i) begin
            t_acc  = treqvalid_i && (!m_rv || trspready_i);
            t_wr   = t_acc && treqdvalid_i;
            t_rd   = t_acc && !treqdvalid_i;
            t_idx  = treqaddr_i[4:2];
            t_tick = m_en && (m_phase == m_ps);
            t_val  = m_read(t_idx);
            m_irq <= m_ie && (m_time >= m_cmp);
            if (t_wr && t_idx == 3'd5) m_phase <= 0;
            else if (m_en) m_phase <= t_tick ? 0 : m_phase + 1;
            if (t_wr && t_idx == 3'd0)      m_time <= {m_time[63:32], treqdata_i};
            else if (t_wr && t_idx == 3'd1) m_time <= {treqdata_i, m_time[31:0]};
            else if (t_tick)                m_time <= m_time + 64'd1;
            if (t_wr && t_idx == 3'd1)      m_shadow <= treqdata_i;
            else if (t_rd && t_idx == 3'd0) m_shadow <= m_time[63:32];
            if (t_wr && t_idx == 3'd2) m_cmp[31:0]  <= treqdata_i;
            if (t_wr && t_idx == 3'd3) m_cmp[63:32] <= treqdata_i;
            if (t_wr && t_idx == 3'd4) begin m_en <= treqdata_i[0]; m_ie <= treqdata_i[1]; end
            if (t_wr && t_idx == 3'd5) m_ps <= treqdata_i[15:0];
            if (t_rd) begin m_rv <= 1'b1; m_rd <= t_val; end
            else if (m_rv && trspready_i) m_rv <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on && !reset_i) begin
            check("irq", {63'd0, irq_o}, {63'd0, m_irq});
            check("rspvalid", {63'd0, trspvalid_o}, {63'd0, m_rv});
            check("reqready", {63'd0, treqready_o}, {63'd0, (!m_rv || trspready_i)});
            if (m_rv) check("rspdata", {32'd0, trspdata_o}, {32'd0, m_rd});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!treqready_o && k < 50) begin cyc(1); k++; end
        if (!treqready_o) check("req_ready_timeout", {63'd0, treqready_o}, 64'd1);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        wait_ready();
        treqvalid_i = 1'b1; treqdvalid_i = 1'b1;
        treqaddr_i = {27'd0, idx, 2'b00}; treqdata_i = d;
        cyc(1);
        treqvalid_i = 1'b0; treqdvalid_i = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d);
        wait_ready();
        treqvalid_i = 1'b1; treqdvalid_i = 1'b0;
        treqaddr_i = {27'd0, idx, 2'b00};
        cyc(1);
        treqvalid_i = 1'b0;
        check("rd_valid", {63'd0, trspvalid_o}, 64'd1);
        d = trspdata_o;
    endtask

    task automatic rd_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        rd(idx, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        logic [31:0] d;
        #1 reset_i = 1'b1;
        cyc(2);
        #1 reset_i = 1'b0;
        chk_on = 1'b1;

        // Reset and read-back, including an asynchronous pulse between edges
        wr(3'd5, 32'd7);
        #1 reset_i = 1'b1;
        #3 reset_i = 1'b0;
        check("rst_irq", {63'd0, irq_o}, 64'd0);
        check("rst_rspvalid", {63'd0, trspvalid_o}, 64'd0);
        check("rst_rspdata", {32'd0, trspdata_o}, 64'd0);
        check("rst_reqready", {63'd0, treqready_o}, 64'd1);
        rd_check("rst_mtime_lo", 3'd0, 32'h0);
        rd_check("rst_mtime_hi", 3'd1, 32'h0);
        rd_check("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd_check("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd_check("rst_ctrl", 3'd4, 32'h0);
        rd_check("rst_prescale", 3'd5, 32'h0);
        rd_check("unmapped_6", 3'd6, 32'h0);
        wr(3'd7, 32'h1234);
        rd_check("unmapped_7", 3'd7, 32'h0);

        // Prescale counting: PRESCALE=3 over ~40 cycles gives 10
        wr(3'd5, 32'd3);
        wr(3'd4, 32'd1);
        cyc(40);
        wr(3'd4, 32'd0);
        rd(3'd0, d);
        check("prescale3_mtime_in_range", {63'd0, (d >= 32'd9 && d <= 32'd11)}, 64'd1);
        rd_check("prescale_readback", 3'd5, 32'd3);

        // PRESCALE=0: one increment per enabled cycle
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);
        cyc(5);
        wr(3'd4, 32'd0);
        rd_check("prescale0_mtime", 3'd0, 32'd6);

        // Low-to-high carry and the shadow high word
        wr(3'd1, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd4, 32'd1);
        cyc(1);
        rd_check("carry_lo_at_max", 3'd0, 32'hFFFF_FFFF);
        cyc(1);
        rd_check("carry_hi_shadow_old", 3'd1, 32'd0);
        rd(3'd0, d);
        rd_check("carry_hi_fresh", 3'd1, 32'd1);
        wr(3'd4, 32'd0);

        // Interrupt rises one cycle after mtime reaches mtimecmp
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'h20);
        wr(3'd4, 32'd3);
        cyc(32);
        check("irq_before_match", {63'd0, irq_o}, 64'd0);
        cyc(1);
        check("irq_after_match", {63'd0, irq_o}, 64'd1);
        wr(3'd2, 32'hFFFF_FFFF);
        check("irq_one_edge_after_cmp_write", {63'd0, irq_o}, 64'd1);
        cyc(1);
        check("irq_two_edges_after_cmp_write", {63'd0, irq_o}, 64'd0);
        wr(3'd4, 32'd1);
        wr(3'd2, 32'h20);
        cyc(3);
        check("irq_masked_by_ie", {63'd0, irq_o}, 64'd0);
        wr(3'd4, 32'd0);

        // Backpressure: response held, request blocked, then pop+accept together
        trspready_i = 1'b0;
        treqvalid_i = 1'b1; treqdvalid_i = 1'b0; treqaddr_i = {27'd0, 3'd2, 2'b00};
        cyc(1);
        treqaddr_i = {27'd0, 3'd3, 2'b00};
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", {63'd0, trspvalid_o}, 64'd1);
            check("bp_data_stable", {32'd0, trspdata_o}, 64'h20);
            check("bp_reqready_low", {63'd0, treqready_o}, 64'd0);
            cyc(1);
        end
        trspready_i = 1'b1;
        #1 check("bp_release_ready", {63'd0, treqready_o}, 64'd1);
        cyc(1);
        check("bp_next_valid", {63'd0, trspvalid_o}, 64'd1);
        check("bp_next_data", {32'd0, trspdata_o}, 64'd0);
        treqaddr_i = {27'd0, 3'd2, 2'b00};
        cyc(1);
        check("b2b_data_0", {32'd0, trspdata_o}, 64'h20);
        treqaddr_i = {27'd0, 3'd5, 2'b00};
        cyc(1);
        check("b2b_data_1", {32'd0, trspdata_o}, 64'd0);
        treqaddr_i = {27'd0, 3'd2, 2'b00};
        cyc(1);
        check("b2b_data_2", {32'd0, trspdata_o}, 64'h20);
        treqvalid_i = 1'b0;
        cyc(1);
        check("b2b_drained", {63'd0, trspvalid_o}, 64'd0);

        // Write to MTIME_LO on a tick cycle wins, then counting resumes
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'h100);
        rd_check("collision_lo_written", 3'd0, 32'h100);
        rd_check("collision_lo_counts", 3'd0, 32'h101);
        rd_check("collision_hi_kept", 3'd1, 32'h0);

        // Clock enable freeze
        clk_en_i = 1'b0;
        cyc(3);
        clk_en_i = 1'b1;
        rd(3'd0, d);

        // Reset with a response pending; held request re-accepted afterwards
        trspready_i = 1'b0;
        treqvalid_i = 1'b1; treqdvalid_i = 1'b0; treqaddr_i = {27'd0, 3'd2, 2'b00};
        cyc(1);
        check("pending_valid", {63'd0, trspvalid_o}, 64'd1);
        #1 reset_i = 1'b1;
        #1 check("reset_drops_valid", {63'd0, trspvalid_o}, 64'd0);
        #2 reset_i = 1'b0;
        cyc(1);
        check("reaccept_valid", {63'd0, trspvalid_o}, 64'd1);
        check("reaccept_data", {32'd0, trspdata_o}, 64'hFFFF_FFFF);
        treqvalid_i = 1'b0;
        trspready_i = 1'b1;
        cyc(2);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
